// File: rtl/ssd1306_spi_decoder.sv
// SSD1306 controller model: mode-0 SPI byte receiver plus command parser.
// Publishes decoded display state and a GDDRAM write port for loopback checking.
module ssd1306_spi_decoder (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       oled_sclk,
  input  logic       oled_sdin,
  input  logic       ss,
  input  logic       oled_dc,
  input  logic       oled_res,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_is_data,
  output logic       display_on,
  output logic [7:0] contrast,
  output logic [5:0] mux_ratio,
  output logic       charge_pump_en,
  output logic [1:0] mem_mode,
  output logic       inverted,
  output logic       entire_on,
  output logic       gram_we,
  output logic [9:0] gram_addr,
  output logic [7:0] gram_wdata,
  output logic       unknown_cmd
);

  typedef enum logic [1:0] {StIdle, StArg1, StArg2} state_e;

  logic [2:0] sclk_q;
  logic [1:0] sdin_q, ss_q, dc_q, res_q;
  logic       sclk_rise_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;

  state_e     state_q;
  logic [7:0] opcode_q;
  logic [6:0] col_q;
  logic [2:0] page_q;
  logic       advance_q;

  assign gram_addr = {page_q, col_q};

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      sdin_q <= '0;
      ss_q   <= 2'b11;
      dc_q   <= '0;
      res_q  <= 2'b11;
    end else begin
      sclk_q <= {sclk_q[1:0], oled_sclk};
      sdin_q <= {sdin_q[0], oled_sdin};
      ss_q   <= {ss_q[0], ss};
      dc_q   <= {dc_q[0], oled_dc};
      res_q  <= {res_q[0], oled_res};
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sclk_rise_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_byte     <= '0;
      rx_is_data  <= 1'b0;
      rx_valid    <= 1'b0;
    end else if (!res_q[1]) begin
      sclk_rise_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_byte     <= '0;
      rx_is_data  <= 1'b0;
      rx_valid    <= 1'b0;
    end else begin
      sclk_rise_q <= sclk_q[1] & ~sclk_q[2];
      rx_valid    <= 1'b0;
      if (ss_q[1]) begin
        bit_cnt_q <= '0;
      end else if (sclk_rise_q) begin
        shift_q   <= {shift_q[5:0], sdin_q[1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_byte    <= {shift_q, sdin_q[1]};
          rx_is_data <= dc_q[1];
          rx_valid   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      opcode_q       <= '0;
      col_q          <= '0;
      page_q         <= '0;
      advance_q      <= 1'b0;
      display_on     <= 1'b0;
      contrast       <= 8'h7F;
      mux_ratio      <= 6'd63;
      charge_pump_en <= 1'b0;
      mem_mode       <= 2'd2;
      inverted       <= 1'b0;
      entire_on      <= 1'b0;
      gram_we        <= 1'b0;
      gram_wdata     <= '0;
      unknown_cmd    <= 1'b0;
    end else if (!res_q[1]) begin
      state_q        <= StIdle;
      opcode_q       <= '0;
      col_q          <= '0;
      page_q         <= '0;
      advance_q      <= 1'b0;
      display_on     <= 1'b0;
      contrast       <= 8'h7F;
      mux_ratio      <= 6'd63;
      charge_pump_en <= 1'b0;
      mem_mode       <= 2'd2;
      inverted       <= 1'b0;
      entire_on      <= 1'b0;
      gram_we        <= 1'b0;
      gram_wdata     <= '0;
      unknown_cmd    <= 1'b0;
    end else begin
      gram_we     <= 1'b0;
      unknown_cmd <= 1'b0;
      advance_q   <= 1'b0;
      // Pointer moves one cycle after the write so gram_addr is stable under gram_we.
      if (advance_q) begin
        unique case (mem_mode)
          2'd0: begin
            col_q <= col_q + 7'd1;
            if (col_q == 7'd127) page_q <= page_q + 3'd1;
          end
          2'd1: begin
            page_q <= page_q + 3'd1;
            if (page_q == 3'd7) col_q <= col_q + 7'd1;
          end
          default: col_q <= col_q + 7'd1;
        endcase
      end
      if (rx_valid) begin
        unique case (state_q)
          StIdle: begin
            if (rx_is_data) begin
              gram_we    <= 1'b1;
              gram_wdata <= rx_byte;
              advance_q  <= 1'b1;
            end else begin
              casez (rx_byte)
                8'hAE, 8'hAF: display_on <= rx_byte[0];
                8'hA4, 8'hA5: entire_on <= rx_byte[0];
                8'hA6, 8'hA7: inverted <= rx_byte[0];
                8'b0000_????: col_q[3:0] <= rx_byte[3:0];
                8'b0001_0???: col_q[6:4] <= rx_byte[2:0];
                8'b1011_0???: page_q <= rx_byte[2:0];
                8'b01??_????, 8'hC0, 8'hC8, 8'hA0, 8'hA1: ;
                8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D, 8'h20, 8'h21,
                8'h22: begin
                  opcode_q <= rx_byte;
                  state_q  <= StArg1;
                end
                default: unknown_cmd <= 1'b1;
              endcase
            end
          end
          StArg1: begin
            unique case (opcode_q)
              8'h81:   contrast <= rx_byte;
              8'hA8:   mux_ratio <= rx_byte[5:0];
              8'h8D:   charge_pump_en <= rx_byte[2];
              8'h20:   mem_mode <= rx_byte[1:0];
              8'h21:   col_q <= rx_byte[6:0];
              8'h22:   page_q <= rx_byte[2:0];
              default: ;
            endcase
            state_q <= (opcode_q == 8'h21 || opcode_q == 8'h22) ? StArg2 : StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
